// File: rtl/trace_match_pkg.sv
// ============================================================================
//  Module      : trace_match_pkg
//  Description : Shared types, constants and the priority encoder for the
//                trace pattern matcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_match_pkg;

  localparam int RULE_IDX_W = 8;
  localparam int ENTRY_W    = 64;
  // Timestamp field width inside an entry; narrower timestamps are zero-padded
  localparam int TS_PAD     = ENTRY_W - RULE_IDX_W;

  typedef struct packed {
    logic [RULE_IDX_W-1:0] rule;
    logic [TS_PAD-1:0]     timestamp;
  } entry_t;

  // Index of the lowest set bit (0 when the vector is empty)
  function automatic logic [RULE_IDX_W-1:0] prio_enc(input logic [63:0] vec);
    logic [RULE_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) idx = RULE_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_match_if.sv
// ============================================================================
//  Module      : trace_match_if
//  Description : Trace frame input and match-FIFO read port of the matcher.
//                master = deframer/register side, slave = matcher.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trace_match_if #(
  parameter int pDATA_WIDTH = 64
) ();
  import trace_match_pkg::*;

  logic [pDATA_WIDTH-1:0] trace_data;
  logic                   trace_valid;
  logic                   fifo_rd;
  logic                   fifo_clear;
  logic [ENTRY_W-1:0]     fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_overflow;

  modport master (
    output trace_data, trace_valid, fifo_rd, fifo_clear,
    input  fifo_dout, fifo_empty, fifo_full, fifo_overflow
  );

  modport slave (
    input  trace_data, trace_valid, fifo_rd, fifo_clear,
    output fifo_dout, fifo_empty, fifo_full, fifo_overflow
  );
endinterface

`default_nettype wire

// File: rtl/trace_match_fifo.sv
// ============================================================================
//  Module      : trace_match_fifo
//  Description : Synchronous first-word-fall-through FIFO of match entries
//                with registered exact full/empty, clear and sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_match_fifo
  import trace_match_pkg::*;
#(
  parameter int pDEPTH = 32
) (
  input  wire logic trace_clk,
  input  wire logic resetn,
  input  wire logic wr_en,
  input  entry_t    wr_data,
  input  wire logic rd_en,
  input  wire logic clear,
  output entry_t    dout,
  output logic      empty,
  output logic      full,
  output logic      overflow
);

  localparam int              c_AW   = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(pDEPTH);
  localparam logic [c_AW:0]   c_ONE  = (c_AW + 1)'(1);

  entry_t            r_mem [pDEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  entry_t            r_dout;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;

  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [c_AW-1:0]   w_rd_nxt;
  logic [c_AW:0]     w_count_nxt;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write
  always_comb begin
    w_rd_ok     = rd_en && !r_empty;
    w_wr_ok     = wr_en && (!r_full || w_rd_ok);
    w_rd_nxt    = r_rd_ptr + 1'b1;
    w_count_nxt = r_count;
    if (w_wr_ok && !w_rd_ok) w_count_nxt = r_count + 1'b1;
    else if (w_rd_ok && !w_wr_ok) w_count_nxt = r_count - 1'b1;
  end

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge trace_clk) begin
    if (resetn && !clear && w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers, flags and the registered head entry
  always_ff @(posedge trace_clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_dout     <= '0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= w_rd_nxt;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == c_FULL);
      if (wr_en && !w_wr_ok) r_overflow <= 1'b1;
      // Head tracks the oldest entry; it holds when the FIFO drains
      if (w_wr_ok && r_empty) begin
        r_dout <= wr_data;
      end else if (w_rd_ok) begin
        if (r_count == c_ONE) begin
          if (w_wr_ok) r_dout <= wr_data;
        end else begin
          r_dout <= r_mem[w_rd_nxt];
        end
      end
    end
  end

  assign dout     = r_dout;
  assign empty    = r_empty;
  assign full     = r_full;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/trace_matcher_n.sv
// ============================================================================
//  Module      : trace_matcher_n
//  Description : Pattern/mask trace matcher. Lowest-index hit drives the
//                trigger and queues a {rule, timestamp} entry.
//                Optional macro TRACE_MATCH_COUNTERS_EN adds per-rule 16-bit
//                saturating hit counters on match_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_matcher_n
  import trace_match_pkg::*;
#(
  parameter int pNUM_RULES  = 8,
  parameter int pDATA_WIDTH = 64,
  parameter int pFIFO_DEPTH = 32,
  parameter int pTS_WIDTH   = 56
) (
  input  wire logic                              trace_clk,
  input  wire logic                              resetn,
  trace_match_if.slave                           bus,
  input  wire logic [pNUM_RULES*pDATA_WIDTH-1:0] patterns,
  input  wire logic [pNUM_RULES*pDATA_WIDTH-1:0] masks,
  input  wire logic [pNUM_RULES-1:0]             pattern_enable,
  input  wire logic                              trig_toggle,
  input  wire logic                              trig_enable,
  output logic                                   trig_out
`ifdef TRACE_MATCH_COUNTERS_EN
  ,
  output logic [pNUM_RULES*16-1:0]               match_count
`endif
);

  logic [pNUM_RULES-1:0] w_hit;
  logic [pNUM_RULES-1:0] r_hit_vec;
  logic [pTS_WIDTH-1:0]  r_ts;
  logic [pTS_WIDTH-1:0]  r_ts_cap;
  logic                  r_trig;
  logic                  w_hit_any;
  entry_t                w_entry;
  entry_t                w_dout;

  generate
    for (genvar gi = 0; gi < pNUM_RULES; gi++) begin : g_rule
      logic [pDATA_WIDTH-1:0] w_diff;
      assign w_diff    = (bus.trace_data ^ patterns[gi*pDATA_WIDTH +: pDATA_WIDTH])
                         & masks[gi*pDATA_WIDTH +: pDATA_WIDTH];
      assign w_hit[gi] = bus.trace_valid && pattern_enable[gi] && (w_diff == '0);
    end
  endgenerate

  // Free-running timestamp plus the compare stage capturing hits and their time
  always_ff @(posedge trace_clk) begin
    if (!resetn) begin
      r_ts      <= '0;
      r_ts_cap  <= '0;
      r_hit_vec <= '0;
    end else begin
      r_ts      <= r_ts + 1'b1;
      r_ts_cap  <= r_ts;
      r_hit_vec <= w_hit;
    end
  end

  // Winning rule and FIFO entry from the registered compare results
  always_comb begin
    w_hit_any         = |r_hit_vec;
    w_entry           = '0;
    w_entry.rule      = prio_enc(64'(r_hit_vec));
    w_entry.timestamp = TS_PAD'(r_ts_cap);
  end

  // Trigger output: pulse follows hit cycles, toggle inverts per hit cycle
  always_ff @(posedge trace_clk) begin
    if (!resetn) begin
      r_trig <= 1'b0;
    end else if (trig_enable) begin
      if (trig_toggle) begin
        if (w_hit_any) r_trig <= ~r_trig;
      end else begin
        r_trig <= w_hit_any;
      end
    end
  end

  assign trig_out = r_trig;

  trace_match_fifo #(
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .trace_clk (trace_clk),
    .resetn    (resetn),
    .wr_en     (w_hit_any),
    .wr_data   (w_entry),
    .rd_en     (bus.fifo_rd),
    .clear     (bus.fifo_clear),
    .dout      (w_dout),
    .empty     (bus.fifo_empty),
    .full      (bus.fifo_full),
    .overflow  (bus.fifo_overflow)
  );

  assign bus.fifo_dout = w_dout;

`ifdef TRACE_MATCH_COUNTERS_EN
  generate
    for (genvar gc = 0; gc < pNUM_RULES; gc++) begin : g_cnt
      logic [15:0] r_cnt;
      // Every hitting rule counts, not only the winner; saturates at 0xFFFF
      always_ff @(posedge trace_clk) begin
        if (!resetn || bus.fifo_clear) begin
          r_cnt <= '0;
        end else if (r_hit_vec[gc] && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      assign match_count[gc*16 +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire
